fetchflare_arbiter: RTL and testbench

FETCHFLARE_ARBITER -- requirements
Module: fetchflare_arbiter

---
 rtl/hpdcache_pkg.sv | 21 ++
 rtl/hwpf_stride_pkg.sv | 9 +
 rtl/fetchflare_rr_arbiter.sv | 40 ++++
 rtl/fetchflare_arbiter.sv | 155 +++++++++++++++
 tb/tb_fetchflare_arbiter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hpdcache_pkg.sv
// rtl/hpdcache_pkg.sv - dcache request/response types shared by dcache clients
package hpdcache_pkg;

    localparam int HPDCACHE_REQ_TRANS_ID_WIDTH = 6;

    typedef logic [HPDCACHE_REQ_TRANS_ID_WIDTH-1:0] hpdcache_req_tid_t;

    typedef struct packed {
        logic [31:0]       addr;
        logic [1:0]        op;
        hpdcache_req_tid_t tid;
        logic              need_rsp;
    } hpdcache_req_t;

    typedef struct packed {
        logic [31:0]       rdata;
        hpdcache_req_tid_t tid;
        logic              error;
    } hpdcache_rsp_t;

endpackage

// File: rtl/hwpf_stride_pkg.sv
// rtl/hwpf_stride_pkg.sv - prefetcher-side constants and engine id type
package hwpf_stride_pkg;

    localparam int FETCHFLARE_MAX_ENGINES  = 8;
    localparam int FETCHFLARE_MAX_INFLIGHT = 8;

    typedef logic [$clog2(FETCHFLARE_MAX_ENGINES)-1:0] fetchflare_eng_id_t;

endpackage

// File: rtl/fetchflare_rr_arbiter.sv
// rtl/fetchflare_rr_arbiter.sv - combinational round-robin selector
// Purpose: picks the first set bit of req starting just after ptr, wrapping.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - index of the last granted requester
//   grant - one-hot grant (zero when no request)
//   idx   - index of the granted requester (zero when no request)
module fetchflare_rr_arbiter
    import hwpf_stride_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  fetchflare_eng_id_t ptr,
    output logic [NUM_REQ-1:0] grant,
    output fetchflare_eng_id_t idx
);

    localparam int IW = $clog2(NUM_REQ);

    logic          found;
    logic [IW-1:0] cand;

    // Walk ptr+1 .. ptr+NUM_REQ so the last grantee gets lowest priority.
    always_comb begin
        found = 1'b0;
        cand  = '0;
        grant = '0;
        idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IW'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = fetchflare_eng_id_t'(cand);
            end
        end
    end

endmodule

// File: rtl/fetchflare_arbiter.sv
// rtl/fetchflare_arbiter.sv - shares one dcache port among prefetch engines
// Purpose: round-robin arbitration into a one-entry request register, inflight
// accounting against MAX_INFLIGHT, and combinational response routing by tid.
// Ports:
//   clk_i, rst_i                              - clock, sync active-high reset
//   eng_req_valid_i/eng_req_ready_o/eng_req_i - per-engine request channel
//   eng_rsp_valid_o/eng_rsp_o                 - per-engine strobe, shared payload
//   hpdcache_req_valid_o/ready_i/req_o        - shared dcache request port
//   hpdcache_rsp_valid_i/rsp_i                - dcache response port
//   inflight_o, busy_o, error_o               - status
module fetchflare_arbiter
    import hpdcache_pkg::*;
    import hwpf_stride_pkg::*;
#(
    parameter int NUM_ENGINES  = 4,
    parameter int MAX_INFLIGHT = FETCHFLARE_MAX_INFLIGHT
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_ENGINES-1:0] eng_req_valid_i,
    output logic [NUM_ENGINES-1:0] eng_req_ready_o,
    input  hpdcache_req_t          eng_req_i [NUM_ENGINES],
    output logic [NUM_ENGINES-1:0] eng_rsp_valid_o,
    output hpdcache_rsp_t          eng_rsp_o,
    output logic                   hpdcache_req_valid_o,
    input  logic                   hpdcache_req_ready_i,
    output hpdcache_req_t          hpdcache_req_o,
    input  logic                   hpdcache_rsp_valid_i,
    input  hpdcache_rsp_t          hpdcache_rsp_i,
    output logic [7:0]             inflight_o,
    output logic                   busy_o,
    output logic                   error_o
);

    localparam int IW = $clog2(NUM_ENGINES);

    generate
        if (IW > HPDCACHE_REQ_TRANS_ID_WIDTH) begin : g_tid_too_narrow
            $error("fetchflare_arbiter: engine index does not fit in dcache tid");
        end
        if (NUM_ENGINES < 2 || NUM_ENGINES > FETCHFLARE_MAX_ENGINES) begin : g_bad_engines
            $error("fetchflare_arbiter: NUM_ENGINES out of range");
        end
        if (MAX_INFLIGHT < 1 || MAX_INFLIGHT > 255) begin : g_bad_inflight
            $error("fetchflare_arbiter: MAX_INFLIGHT out of range");
        end
    endgenerate

    typedef enum logic {
        ST_EMPTY,
        ST_HELD
    } state_t;

    state_t             state_q;
    hpdcache_req_t      req_q;
    logic [7:0]         inflight_q;
    fetchflare_eng_id_t ptr_q;
    logic               error_q;

    logic [NUM_ENGINES-1:0] rr_grant;
    fetchflare_eng_id_t     rr_idx;
    logic [IW-1:0]          sel;
    hpdcache_req_t          grant_req;
    logic                   held;
    logic                   handshake;
    logic                   room;
    logic                   accept;
    logic                   rsp_spurious;
    logic                   rsp_bad_tid;
    logic                   rsp_error;

    fetchflare_rr_arbiter #(
        .NUM_REQ (NUM_ENGINES)
    ) u_rr (
        .req   (eng_req_valid_i),
        .ptr   (ptr_q),
        .grant (rr_grant),
        .idx   (rr_idx)
    );

    assign held      = (state_q == ST_HELD);
    assign handshake = held && hpdcache_req_ready_i;

    // The held entry counts against the limit: it becomes inflight as soon as
    // the dcache takes it, and a new accept refills the register that cycle.
    assign room = ({1'b0, inflight_q} + {8'b0, held}) < 9'(MAX_INFLIGHT);

    // Reset gates acceptance so nothing is granted into a register being cleared.
    assign accept = !rst_i && (!held || hpdcache_req_ready_i) && room
                    && (|eng_req_valid_i);

    assign eng_req_ready_o = accept ? rr_grant : '0;

    assign sel = IW'(rr_idx);

    always_comb begin
        grant_req     = eng_req_i[sel];
        grant_req.tid = hpdcache_req_tid_t'(rr_idx);
    end

    // A response with nothing outstanding cannot belong to any engine, so it
    // is dropped like an out-of-range tid.
    assign rsp_spurious = (inflight_q == 8'd0);
    assign rsp_bad_tid  = (int'(hpdcache_rsp_i.tid) >= NUM_ENGINES);
    assign rsp_error    = hpdcache_rsp_valid_i && (rsp_spurious || rsp_bad_tid);

    always_comb begin
        eng_rsp_valid_o = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            eng_rsp_valid_o[i] = hpdcache_rsp_valid_i && !rsp_spurious
                                 && (hpdcache_rsp_i.tid == hpdcache_req_tid_t'(i));
        end
    end

    assign eng_rsp_o = hpdcache_rsp_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_EMPTY;
            req_q      <= '0;
            inflight_q <= 8'd0;
            ptr_q      <= fetchflare_eng_id_t'(NUM_ENGINES - 1);
            error_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) state_q <= ST_HELD;
                ST_HELD:  if (handshake && !accept) state_q <= ST_EMPTY;
                default:  state_q <= ST_EMPTY;
            endcase

            if (accept) begin
                req_q <= grant_req;
                ptr_q <= rr_idx;
            end

            // Simultaneous issue and return cancel out.
            if (handshake && !hpdcache_rsp_valid_i) begin
                inflight_q <= inflight_q + 8'd1;
            end else if (!handshake && hpdcache_rsp_valid_i && !rsp_spurious) begin
                inflight_q <= inflight_q - 8'd1;
            end

            if (rsp_error) begin
                error_q <= 1'b1;
            end
        end
    end

    assign hpdcache_req_valid_o = held;
    assign hpdcache_req_o       = req_q;
    assign inflight_o           = inflight_q;
    assign busy_o               = held || (inflight_q != 8'd0);
    assign error_o              = error_q;

endmodule

// File: tb/tb_fetchflare_arbiter.sv
// tb/tb_fetchflare_arbiter.sv - directed self-checking bench for fetchflare_arbiter
module tb_fetchflare_arbiter;
    import hpdcache_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [3:0]    vld, rdy, ersp_v;
    hpdcache_req_t ereq [4];
    hpdcache_rsp_t ersp, rsp;
    logic          hv, hr, rv, busy, err;
    hpdcache_req_t hq;
    logic [7:0]    infl;

    logic [3:0]    vld1, rdy1, ersp_v1;
    hpdcache_rsp_t ersp1, rsp1;
    logic          hv1, hr1, rv1, busy1, err1;
    hpdcache_req_t hq1;
    logic [7:0]    infl1;

    fetchflare_arbiter #(.NUM_ENGINES(4), .MAX_INFLIGHT(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .eng_req_valid_i(vld), .eng_req_ready_o(rdy), .eng_req_i(ereq),
        .eng_rsp_valid_o(ersp_v), .eng_rsp_o(ersp),
        .hpdcache_req_valid_o(hv), .hpdcache_req_ready_i(hr), .hpdcache_req_o(hq),
        .hpdcache_rsp_valid_i(rv), .hpdcache_rsp_i(rsp),
        .inflight_o(infl), .busy_o(busy), .error_o(err)
    );

    fetchflare_arbiter #(.NUM_ENGINES(4), .MAX_INFLIGHT(1)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .eng_req_valid_i(vld1), .eng_req_ready_o(rdy1), .eng_req_i(ereq),
        .eng_rsp_valid_o(ersp_v1), .eng_rsp_o(ersp1),
        .hpdcache_req_valid_o(hv1), .hpdcache_req_ready_i(hr1), .hpdcache_req_o(hq1),
        .hpdcache_rsp_valid_i(rv1), .hpdcache_rsp_i(rsp1),
        .inflight_o(infl1), .busy_o(busy1), .error_o(err1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            ereq[i].addr     = 32'h1000 + 32'(i) * 32'h40;
            ereq[i].op       = 2'(i);
            ereq[i].tid      = 6'h3f;
            ereq[i].need_rsp = 1'b1;
        end
        rst = 1'b1; vld = '0; hr = 1'b0; rv = 1'b0; rsp = '0;
        vld1 = '0; hr1 = 1'b0; rv1 = 1'b0; rsp1 = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        settle();
        chk("reset_valid", 32'(hv), 32'd0);
        chk("reset_inflight", 32'(infl), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_error", 32'(err), 32'd0);
        chk("reset_ready", 32'(rdy), 32'd0);
        tick();

        // All engines valid, dcache always ready: 0,1,2,3,0,1,2,3 then stall
        vld = 4'hf; hr = 1'b1;
        for (int k = 0; k < 8; k++) begin
            settle();
            chk("rr_grant", 32'(rdy), 32'(1 << (k % 4)));
            if (k > 0) chk("rr_tid", 32'(hq.tid), 32'((k - 1) % 4));
            tick();
        end
        settle();
        chk("limit_ready_held", 32'(rdy), 32'd0);
        chk("limit_last_tid", 32'(hq.tid), 32'd3);
        tick();
        settle();
        chk("limit_ready_empty", 32'(rdy), 32'd0);
        chk("limit_valid", 32'(hv), 32'd0);
        chk("limit_inflight", 32'(infl), 32'd8);
        tick();

        // Drain five responses to engine 0
        vld = '0; hr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rv = 1'b1; rsp.tid = 6'd0; rsp.rdata = 32'ha000 + 32'(k);
            settle();
            chk("drain_strobe", 32'(ersp_v), 32'h1);
            chk("drain_rdata", ersp.rdata, 32'ha000 + 32'(k));
            tick();
        end
        rv = 1'b0;
        settle();
        chk("drain_inflight", 32'(infl), 32'd3);
        tick();

        // Response tid=1 in the same cycle as a handshake
        vld = 4'b0100; hr = 1'b1;
        settle();
        chk("same_cycle_grant", 32'(rdy), 32'h4);
        tick();
        vld = '0; rv = 1'b1; rsp.tid = 6'd1;
        settle();
        chk("same_cycle_strobe", 32'(ersp_v), 32'h2);
        chk("same_cycle_valid", 32'(hv), 32'd1);
        tick();
        rv = 1'b0;
        settle();
        chk("same_cycle_inflight", 32'(infl), 32'd3);
        chk("same_cycle_empty", 32'(hv), 32'd0);
        tick();

        // Out-of-range tid and response with nothing outstanding
        rv = 1'b1; rsp.tid = 6'd6;
        settle();
        chk("bad_tid_strobe", 32'(ersp_v), 32'd0);
        tick();
        rv = 1'b0;
        settle();
        chk("bad_tid_error", 32'(err), 32'd1);
        chk("bad_tid_inflight", 32'(infl), 32'd2);
        tick();
        rv = 1'b1; rsp.tid = 6'd0;
        settle(); tick();
        settle(); tick();
        rsp.tid = 6'd3;
        settle();
        chk("spurious_strobe", 32'(ersp_v), 32'd0);
        tick();
        rv = 1'b0;
        settle();
        chk("spurious_inflight", 32'(infl), 32'd0);
        chk("error_sticky", 32'(err), 32'd1);
        tick();

        // Reset while HELD with five outstanding
        rst = 1'b1; tick(); rst = 1'b0;
        vld = 4'hf; hr = 1'b1;
        for (int k = 0; k < 6; k++) begin
            settle(); tick();
        end
        vld = '0; hr = 1'b0;
        settle();
        chk("pre_rst_valid", 32'(hv), 32'd1);
        chk("pre_rst_inflight", 32'(infl), 32'd5);
        chk("pre_rst_tid", 32'(hq.tid), 32'd1);
        tick();
        rst = 1'b1; vld = 4'b1001;
        settle();
        chk("rst_ready", 32'(rdy), 32'd0);
        tick();
        rst = 1'b0; hr = 1'b1;
        settle();
        chk("post_rst_valid", 32'(hv), 32'd0);
        chk("post_rst_inflight", 32'(infl), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_error", 32'(err), 32'd0);
        chk("post_rst_grant", 32'(rdy), 32'h1);
        tick();
        vld = '0;
        settle();
        chk("post_rst_tid", 32'(hq.tid), 32'd0);
        tick();
        hr = 1'b0; rv = 1'b1; rsp.tid = 6'd0;
        settle();
        chk("post_rst_inflight1", 32'(infl), 32'd1);
        chk("post_rst_strobe", 32'(ersp_v), 32'h1);
        tick();
        rv = 1'b0;
        settle();
        chk("post_rst_drained", 32'(infl), 32'd0);
        tick();

        // Engine 2 held with ready low for three cycles
        vld = 4'b0100; hr = 1'b0;
        settle();
        chk("hold_grant", 32'(rdy), 32'h4);
        tick();
        vld = '0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("hold_valid", 32'(hv), 32'd1);
            chk("hold_tid", 32'(hq.tid), 32'd2);
            chk("hold_addr", hq.addr, 32'h1080);
            chk("hold_op", 32'(hq.op), 32'd2);
            tick();
        end
        hr = 1'b1;
        settle();
        chk("hold_hs_valid", 32'(hv), 32'd1);
        tick();
        hr = 1'b0;
        settle();
        chk("hold_done_valid", 32'(hv), 32'd0);
        chk("hold_inflight", 32'(infl), 32'd1);
        tick();

        // MAX_INFLIGHT=1, engines 0 and 3
        vld1 = 4'b1001; hr1 = 1'b1;
        settle();
        chk("lim1_grant0", 32'(rdy1), 32'h1);
        tick();
        settle();
        chk("lim1_held_ready", 32'(rdy1), 32'd0);
        chk("lim1_valid", 32'(hv1), 32'd1);
        tick();
        settle();
        chk("lim1_wait_ready", 32'(rdy1), 32'd0);
        chk("lim1_inflight", 32'(infl1), 32'd1);
        tick();
        rv1 = 1'b1; rsp1.tid = 6'd0;
        settle();
        chk("lim1_strobe", 32'(ersp_v1), 32'h1);
        chk("lim1_rsp_ready", 32'(rdy1), 32'd0);
        tick();
        rv1 = 1'b0;
        settle();
        chk("lim1_grant3", 32'(rdy1), 32'h8);
        tick();
        vld1 = '0;
        settle();
        chk("lim1_tid3", 32'(hq1.tid), 32'd3);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
